ch_sweep_ctl: RTL and testbench

//  Parametrised per-channel threshold/delay sweep controller; successor of the single-width measure controller.
//  For each delay code it ramps the DAC threshold, majority-votes N comparator samples per step, and reports the 1->0 crossing.

---
 rtl/ch_sweep_ctl.sv | 252 +++++++++++++++++++++++++
 tb/tb_ch_sweep_ctl.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ch_sweep_ctl.sv
// ch_sweep_ctl -- per-channel threshold/delay sweep controller.
//
// For every delay-line code the DAC threshold is ramped from 0 in steps of
// th_delta. At each step N comparator samples (taken on rising strobe edges
// while the DAC reports settled) are majority-voted. The first 1->0 vote
// transition is reported as a crossing point; reaching the threshold ceiling
// without one reports a miss point. After each point is accepted the delay
// code advances by dc_delta until it would exceed the delay-code ceiling.
//
// Ports:
//   clk_i, arst_ni                 clock, asynchronous active-low reset
//   stb_i, cmp_out_i               strobe and comparator sample input
//   cfg_wr_i, cfg_*_i              configuration load (only while idle)
//   run_i, abort_i                 sweep start (level) and cancel
//   busy_o, done_o                 activity flag, normal-completion pulse
//   threshold_o, threshold_wre_o   DAC code and write strobe
//   threshold_rdy_i                DAC settled
//   d_code_o                       delay-line code
//   point_valid_o/point_ready_i    result handshake
//   point_v_o, point_t_o,
//   point_miss_o                   result payload
module ch_sweep_ctl #(
  parameter int TH_W             = 16,
  parameter int DC_W             = 10,
  parameter int CNT_W            = 4,
  parameter int DEFAULT_TH_DELTA = 1,
  parameter int DEFAULT_DC_DELTA = 1
) (
  input  logic             clk_i,
  input  logic             arst_ni,
  input  logic             stb_i,
  input  logic             cmp_out_i,
  input  logic             cfg_wr_i,
  input  logic [TH_W-1:0]  cfg_th_delta_i,
  input  logic [DC_W-1:0]  cfg_dc_delta_i,
  input  logic [TH_W-1:0]  cfg_th_max_i,
  input  logic [DC_W-1:0]  cfg_dc_max_i,
  input  logic [CNT_W-1:0] cfg_votes_i,
  input  logic             run_i,
  input  logic             abort_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [TH_W-1:0]  threshold_o,
  output logic             threshold_wre_o,
  input  logic             threshold_rdy_i,
  output logic [DC_W-1:0]  d_code_o,
  output logic             point_valid_o,
  input  logic             point_ready_i,
  output logic [TH_W-1:0]  point_v_o,
  output logic [DC_W-1:0]  point_t_o,
  output logic             point_miss_o
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_SET, ST_WAIT, ST_SAMPLE, ST_EMIT
  } state_e;

  state_e           state_q, state_d;
  logic             stb_prev_q, stb_prev_d;
  logic [TH_W-1:0]  th_delta_q, th_delta_d, th_max_q, th_max_d;
  logic [DC_W-1:0]  dc_delta_q, dc_delta_d, dc_max_q, dc_max_d;
  logic [CNT_W-1:0] votes_q, votes_d;
  logic [TH_W-1:0]  threshold_q, threshold_d;
  logic [DC_W-1:0]  d_code_q, d_code_d;
  logic             wre_q, wre_d, busy_q, busy_d, done_q, done_d;
  logic             valid_q, valid_d;
  logic [TH_W-1:0]  pv_q, pv_d;
  logic [DC_W-1:0]  pt_q, pt_d;
  logic             pmiss_q, pmiss_d;
  logic             prev_valid_q, prev_valid_d, prev_vote_q, prev_vote_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, ones_q, ones_d;
  logic             wait_first_q, wait_first_d;

  logic             stb_rise;
  logic [CNT_W-1:0] eff_votes, cnt_inc, ones_inc;
  logic             vote;
  logic [TH_W:0]    th_sum;
  logic [DC_W:0]    dc_sum;

  // Sums are one bit wider so a step past the ceiling is seen instead of wrapping.
  assign stb_rise  = stb_i & ~stb_prev_q;
  assign eff_votes = (votes_q == '0) ? CNT_W'(1) : votes_q;
  assign cnt_inc   = cnt_q + CNT_W'(1);
  assign ones_inc  = ones_q + CNT_W'(cmp_out_i);
  assign vote      = {ones_inc, 1'b0} > {1'b0, eff_votes};
  assign th_sum    = {1'b0, threshold_q} + {1'b0, th_delta_q};
  assign dc_sum    = {1'b0, d_code_q} + {1'b0, dc_delta_q};

  always_comb begin
    state_d      = state_q;
    stb_prev_d   = stb_i;
    th_delta_d   = th_delta_q;
    th_max_d     = th_max_q;
    dc_delta_d   = dc_delta_q;
    dc_max_d     = dc_max_q;
    votes_d      = votes_q;
    threshold_d  = threshold_q;
    d_code_d     = d_code_q;
    pv_d         = pv_q;
    pt_d         = pt_q;
    pmiss_d      = pmiss_q;
    prev_valid_d = prev_valid_q;
    prev_vote_d  = prev_vote_q;
    cnt_d        = cnt_q;
    ones_d       = ones_q;
    wait_first_d = wait_first_q;
    done_d       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (cfg_wr_i) begin
          th_delta_d = cfg_th_delta_i;
          dc_delta_d = cfg_dc_delta_i;
          th_max_d   = cfg_th_max_i;
          dc_max_d   = cfg_dc_max_i;
          votes_d    = cfg_votes_i;
        end
        if (run_i) begin
          threshold_d  = '0;
          d_code_d     = '0;
          prev_valid_d = 1'b0;
          state_d      = ST_SET;
        end
      end
      ST_SET: begin
        cnt_d        = '0;
        ones_d       = '0;
        wait_first_d = 1'b1;
        state_d      = ST_WAIT;
      end
      // The DAC only drops rdy a cycle after the write, so skip that cycle.
      ST_WAIT: begin
        if (wait_first_q) begin
          wait_first_d = 1'b0;
        end else if (threshold_rdy_i) begin
          state_d = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        if (stb_rise && threshold_rdy_i) begin
          cnt_d  = cnt_inc;
          ones_d = ones_inc;
          if (cnt_inc == eff_votes) begin
            if (prev_valid_q && prev_vote_q && !vote) begin
              pv_d    = threshold_q;
              pt_d    = d_code_q;
              pmiss_d = 1'b0;
              state_d = ST_EMIT;
            end else begin
              prev_vote_d  = vote;
              prev_valid_d = 1'b1;
              if (th_sum > {1'b0, th_max_q}) begin
                pv_d    = threshold_q;
                pt_d    = d_code_q;
                pmiss_d = 1'b1;
                state_d = ST_EMIT;
              end else begin
                threshold_d = th_sum[TH_W-1:0];
                state_d     = ST_SET;
              end
            end
          end
        end
      end
      ST_EMIT: begin
        if (valid_q && point_ready_i) begin
          if (dc_sum > {1'b0, dc_max_q}) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            d_code_d     = dc_sum[DC_W-1:0];
            threshold_d  = '0;
            prev_valid_d = 1'b0;
            state_d      = ST_SET;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort wins over everything, including a run request seen in idle.
    if (abort_i) begin
      state_d     = ST_IDLE;
      done_d      = 1'b0;
      threshold_d = threshold_q;
      d_code_d    = d_code_q;
    end

    wre_d   = (state_d == ST_SET);
    busy_d  = (state_d != ST_IDLE);
    valid_d = (state_d == ST_EMIT);
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q      <= ST_IDLE;
      stb_prev_q   <= 1'b0;
      th_delta_q   <= TH_W'(DEFAULT_TH_DELTA);
      dc_delta_q   <= DC_W'(DEFAULT_DC_DELTA);
      th_max_q     <= '1;
      dc_max_q     <= '1;
      votes_q      <= CNT_W'(1);
      threshold_q  <= '0;
      d_code_q     <= '0;
      wre_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      valid_q      <= 1'b0;
      pv_q         <= '0;
      pt_q         <= '0;
      pmiss_q      <= 1'b0;
      prev_valid_q <= 1'b0;
      prev_vote_q  <= 1'b0;
      cnt_q        <= '0;
      ones_q       <= '0;
      wait_first_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      stb_prev_q   <= stb_prev_d;
      th_delta_q   <= th_delta_d;
      dc_delta_q   <= dc_delta_d;
      th_max_q     <= th_max_d;
      dc_max_q     <= dc_max_d;
      votes_q      <= votes_d;
      threshold_q  <= threshold_d;
      d_code_q     <= d_code_d;
      wre_q        <= wre_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      valid_q      <= valid_d;
      pv_q         <= pv_d;
      pt_q         <= pt_d;
      pmiss_q      <= pmiss_d;
      prev_valid_q <= prev_valid_d;
      prev_vote_q  <= prev_vote_d;
      cnt_q        <= cnt_d;
      ones_q       <= ones_d;
      wait_first_q <= wait_first_d;
    end
  end

  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign threshold_o     = threshold_q;
  assign threshold_wre_o = wre_q;
  assign d_code_o        = d_code_q;
  assign point_valid_o   = valid_q;
  assign point_v_o       = pv_q;
  assign point_t_o       = pt_q;
  assign point_miss_o    = pmiss_q;

endmodule

// File: tb/tb_ch_sweep_ctl.sv
// Testbench for ch_sweep_ctl: a DAC/strobe agent answers threshold writes,
// directed sweeps push their hand-computed points into a queue, and a
// monitor pops and compares on every accepted result.
module tb_ch_sweep_ctl;
  localparam int TH_W  = 16;
  localparam int DC_W  = 10;
  localparam int CNT_W = 4;

  typedef struct {
    logic [TH_W-1:0] v;
    logic [DC_W-1:0] t;
    logic            miss;
  } point_t;

  logic             clk_i = 1'b0;
  logic             arst_ni;
  logic             stb_i, cmp_out_i, cfg_wr_i, run_i, abort_i;
  logic [TH_W-1:0]  cfg_th_delta_i, cfg_th_max_i;
  logic [DC_W-1:0]  cfg_dc_delta_i, cfg_dc_max_i;
  logic [CNT_W-1:0] cfg_votes_i;
  logic             busy_o, done_o, threshold_wre_o, threshold_rdy_i;
  logic [TH_W-1:0]  threshold_o, point_v_o;
  logic [DC_W-1:0]  d_code_o, point_t_o;
  logic             point_valid_o, point_ready_i, point_miss_o;

  point_t           exp_q[$];
  logic [TH_W-1:0]  wre_log[$];
  int compared   = 0;
  int mismatched = 0;
  int done_cnt   = 0;
  int cmp_mode   = 0;
  int cmp_limit  = 5;
  int gap_en     = 0;
  int gap_th     = 0;

  ch_sweep_ctl #(.TH_W(TH_W), .DC_W(DC_W), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .arst_ni(arst_ni), .stb_i(stb_i), .cmp_out_i(cmp_out_i),
    .cfg_wr_i(cfg_wr_i), .cfg_th_delta_i(cfg_th_delta_i),
    .cfg_dc_delta_i(cfg_dc_delta_i), .cfg_th_max_i(cfg_th_max_i),
    .cfg_dc_max_i(cfg_dc_max_i), .cfg_votes_i(cfg_votes_i),
    .run_i(run_i), .abort_i(abort_i), .busy_o(busy_o), .done_o(done_o),
    .threshold_o(threshold_o), .threshold_wre_o(threshold_wre_o),
    .threshold_rdy_i(threshold_rdy_i), .d_code_o(d_code_o),
    .point_valid_o(point_valid_o), .point_ready_i(point_ready_i),
    .point_v_o(point_v_o), .point_t_o(point_t_o), .point_miss_o(point_miss_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic pushPoint(input int v, input int t, input logic miss);
    point_t p;
    p.v = TH_W'(v);
    p.t = DC_W'(t);
    p.miss = miss;
    exp_q.push_back(p);
  endtask

  // Comparator behaviour as a function of the DAC code and sample index.
  function automatic logic cmpModel(input logic [TH_W-1:0] th, input int idx);
    case (cmp_mode)
      0: return (int'(th) < cmp_limit);
      1: begin
        if (th < 3) return 1'b1;
        if (th == 3) return (idx != 1);
        if (th == 4) return (idx == 2);
        return 1'b0;
      end
      default: return 1'b1;
    endcase
  endfunction

  // DAC and strobe agent: rdy low for 3 cycles after each write, optional
  // window of strobes with rdy low, then one strobe every 3 cycles.
  initial begin
    int settle, phase, sample_idx, gap_left;
    logic [TH_W-1:0] cur_th;
    settle = 0; phase = 0; sample_idx = 0; gap_left = 0; cur_th = '0;
    stb_i = 1'b0; cmp_out_i = 1'b0; threshold_rdy_i = 1'b1;
    forever begin
      @(negedge clk_i);
      if (!arst_ni) begin
        settle = 0; gap_left = 0; phase = 0;
        stb_i = 1'b0; threshold_rdy_i = 1'b1;
      end else if (threshold_wre_o) begin
        cur_th = threshold_o;
        wre_log.push_back(threshold_o);
        sample_idx = 0; phase = 0; settle = 3;
        gap_left = (gap_en != 0 && int'(threshold_o) == gap_th) ? 6 : 0;
        stb_i = 1'b0; threshold_rdy_i = 1'b0;
      end else if (settle > 0) begin
        settle--;
        if (settle == 0) threshold_rdy_i = 1'b1;
      end else if (gap_left > 0) begin
        threshold_rdy_i = 1'b0;
        stb_i = (gap_left % 2 == 0);
        cmp_out_i = 1'b0;
        gap_left--;
        if (gap_left == 0) threshold_rdy_i = 1'b1;
      end else begin
        if (phase == 0) begin
          cmp_out_i = cmpModel(cur_th, sample_idx);
          stb_i = 1'b1;
          sample_idx++;
        end else begin
          stb_i = 1'b0;
        end
        phase = (phase + 1) % 3;
      end
    end
  end

  // Monitor: every accepted point is compared against the queue head.
  initial begin
    point_t e;
    forever begin
      @(negedge clk_i);
      if (arst_ni && done_o) done_cnt++;
      if (arst_ni && point_valid_o && point_ready_i) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL unexpected_point: got v=%0d t=%0d miss=%0d expected none",
                   point_v_o, point_t_o, point_miss_o);
        end else begin
          e = exp_q.pop_front();
          checkOutput("point_v", 64'(point_v_o), 64'(e.v));
          checkOutput("point_t", 64'(point_t_o), 64'(e.t));
          checkOutput("point_miss", 64'(point_miss_o), 64'(e.miss));
        end
      end
    end
  end

  task automatic applyStimulus(input int th_delta, input int dc_delta,
                               input int th_max, input int dc_max, input int votes);
    @(posedge clk_i); #1;
    cfg_th_delta_i = TH_W'(th_delta);
    cfg_dc_delta_i = DC_W'(dc_delta);
    cfg_th_max_i   = TH_W'(th_max);
    cfg_dc_max_i   = DC_W'(dc_max);
    cfg_votes_i    = CNT_W'(votes);
    cfg_wr_i = 1'b1;
    run_i    = 1'b1;
    @(posedge clk_i); #1;
    cfg_wr_i = 1'b0;
    run_i    = 1'b0;
  endtask

  task automatic waitDone(input string name, input int budget);
    int start;
    int n;
    start = done_cnt;
    n = 0;
    while (done_cnt == start && n < budget) begin
      @(posedge clk_i);
      n++;
    end
    repeat (5) @(posedge clk_i);
    #1;
    checkOutput({name, "_done_count"}, 64'(done_cnt - start), 64'd1);
    checkOutput({name, "_busy_after"}, 64'(busy_o), 64'd0);
    checkOutput({name, "_points_left"}, 64'(exp_q.size()), 64'd0);
    if (busy_o) begin
      abort_i = 1'b1;
      @(posedge clk_i); #1;
      abort_i = 1'b0;
    end
    exp_q.delete();
  endtask

  task automatic waitValid(input string name, input int budget);
    int n;
    n = 0;
    while (!point_valid_o && n < budget) begin
      @(posedge clk_i); #1;
      n++;
    end
    checkOutput({name, "_valid_seen"}, 64'(point_valid_o), 64'd1);
  endtask

  initial begin
    int start;
    arst_ni = 1'b0;
    cfg_wr_i = 1'b0; run_i = 1'b0; abort_i = 1'b0; point_ready_i = 1'b1;
    cfg_th_delta_i = '0; cfg_dc_delta_i = '0; cfg_th_max_i = '0;
    cfg_dc_max_i = '0; cfg_votes_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    checkOutput("rst_busy", 64'(busy_o), 64'd0);
    checkOutput("rst_done", 64'(done_o), 64'd0);
    checkOutput("rst_valid", 64'(point_valid_o), 64'd0);
    checkOutput("rst_wre", 64'(threshold_wre_o), 64'd0);
    checkOutput("rst_threshold", 64'(threshold_o), 64'd0);
    checkOutput("rst_dcode", 64'(d_code_o), 64'd0);
    arst_ni = 1'b1;

    $display("[TB] sweep N=1, crossing at 5, three delay codes");
    cmp_mode = 0; cmp_limit = 5;
    pushPoint(5, 0, 1'b0); pushPoint(5, 1, 1'b0); pushPoint(5, 2, 1'b0);
    applyStimulus(1, 1, 15, 2, 1);
    repeat (5) @(posedge clk_i);
    #1;
    cfg_wr_i = 1'b1; cfg_dc_max_i = '0; cfg_th_max_i = 16'd1;
    @(posedge clk_i); #1;
    cfg_wr_i = 1'b0;
    waitDone("t1", 3000);

    $display("[TB] sweep N=3 majority vote");
    cmp_mode = 1;
    pushPoint(4, 0, 1'b0);
    applyStimulus(1, 1, 15, 0, 3);
    waitDone("t2", 3000);

    $display("[TB] ceiling miss without wrap");
    cmp_mode = 2;
    wre_log.delete();
    pushPoint(6, 0, 1'b1);
    applyStimulus(3, 1, 7, 0, 1);
    waitDone("t3", 3000);
    checkOutput("t3_wre_count", 64'(wre_log.size()), 64'd3);
    if (wre_log.size() == 3) begin
      checkOutput("t3_wre0", 64'(wre_log[0]), 64'd0);
      checkOutput("t3_wre1", 64'(wre_log[1]), 64'd3);
      checkOutput("t3_wre2", 64'(wre_log[2]), 64'd6);
    end

    $display("[TB] back-pressure on the result port");
    cmp_mode = 2;
    point_ready_i = 1'b0;
    pushPoint(2, 0, 1'b1); pushPoint(2, 1, 1'b1);
    applyStimulus(1, 1, 2, 1, 1);
    waitValid("t4", 2000);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk_i); #1;
      checkOutput("t4_hold_valid", 64'(point_valid_o), 64'd1);
      checkOutput("t4_hold_v", 64'(point_v_o), 64'd2);
      checkOutput("t4_hold_t", 64'(point_t_o), 64'd0);
      checkOutput("t4_hold_miss", 64'(point_miss_o), 64'd1);
      checkOutput("t4_wre_silent", 64'(threshold_wre_o), 64'd0);
    end
    point_ready_i = 1'b1;
    waitDone("t4", 3000);

    $display("[TB] strobes ignored while DAC not ready, then abort in EMIT");
    cmp_mode = 2; gap_en = 1; gap_th = 1;
    point_ready_i = 1'b0;
    applyStimulus(1, 1, 3, 0, 1);
    waitValid("t5", 2000);
    checkOutput("t5_v", 64'(point_v_o), 64'd3);
    checkOutput("t5_miss", 64'(point_miss_o), 64'd1);
    start = done_cnt;
    abort_i = 1'b1;
    @(posedge clk_i); #1;
    abort_i = 1'b0;
    checkOutput("t5_abort_valid", 64'(point_valid_o), 64'd0);
    checkOutput("t5_abort_busy", 64'(busy_o), 64'd0);
    checkOutput("t5_abort_thr_hold", 64'(threshold_o), 64'd3);
    repeat (5) @(posedge clk_i);
    #1;
    checkOutput("t5_no_done", 64'(done_cnt - start), 64'd0);
    gap_en = 0;
    point_ready_i = 1'b1;

    $display("[TB] delay-code overflow past 10 bits");
    cmp_mode = 0; cmp_limit = 5;
    pushPoint(5, 0, 1'b0); pushPoint(5, 600, 1'b0);
    applyStimulus(1, 600, 15, 1023, 1);
    waitDone("t6", 3000);

    $display("[TB] run and abort together in idle");
    @(posedge clk_i); #1;
    run_i = 1'b1; abort_i = 1'b1;
    @(posedge clk_i); #1;
    run_i = 1'b0; abort_i = 1'b0;
    checkOutput("t7_busy", 64'(busy_o), 64'd0);
    repeat (2) @(posedge clk_i);
    #1;
    checkOutput("t7_wre", 64'(threshold_wre_o), 64'd0);

    $display("[TB] reset mid-sweep");
    cmp_mode = 2;
    applyStimulus(1, 1, 15, 3, 1);
    repeat (20) @(posedge clk_i);
    #1;
    checkOutput("t8_busy_before", 64'(busy_o), 64'd1);
    arst_ni = 1'b0;
    #1;
    checkOutput("t8_busy", 64'(busy_o), 64'd0);
    checkOutput("t8_valid", 64'(point_valid_o), 64'd0);
    checkOutput("t8_threshold", 64'(threshold_o), 64'd0);
    checkOutput("t8_dcode", 64'(d_code_o), 64'd0);
    checkOutput("t8_points_left", 64'(exp_q.size()), 64'd0);
    repeat (2) @(posedge clk_i);
    #1;
    arst_ni = 1'b1;
    repeat (3) @(posedge clk_i);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
